// File: rtl/relu_layer_sequencer.sv
// Streams one layer of accumulator words through the shared registered ReLU into the next-layer buffer, counting positive results.
// Latency: N+4 cycles from start to done with a 1-cycle ReLU; no backpressure, completion is tracked by counting ReLU returns.
module relu_layer_sequencer #(
    parameter int DATA_W      = 16,
    parameter int NUM_NEURONS = 32,
    parameter int ADDR_W      = $clog2(NUM_NEURONS),
    parameter int CNT_W       = $clog2(NUM_NEURONS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  layer_size,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  nz_count,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_rd_addr,
    input  logic [DATA_W-1:0] src_rd_data,
    output logic [DATA_W-1:0] relu_in_data,
    output logic              relu_in_valid,
    input  logic [DATA_W-1:0] relu_out_data,
    input  logic              relu_out_valid,
    output logic              dst_wr_en,
    output logic [ADDR_W-1:0] dst_wr_addr,
    output logic [DATA_W-1:0] dst_wr_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(NUM_NEURONS);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   n_q;
    logic [CNT_W-1:0]   n_clamp;
    logic [CNT_W-1:0]   rd_cnt;
    logic [CNT_W-1:0]   wr_cnt;
    logic [CNT_W-1:0]   nz_q;
    logic               rd_en_q;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [DATA_W-1:0]  wr_data_q;
    logic               accept_start;
    logic               in_run;
    logic               wr_accept;
    logic               result_pos;

    assign n_clamp    = (layer_size > MAX_N) ? MAX_N : layer_size;
    assign in_run     = (state == FETCH) || (state == DRAIN);
    // Returns beyond N, outside a run, or coinciding with an abort never reach the buffer.
    assign wr_accept  = in_run && relu_out_valid && !abort && (wr_cnt < n_q);
    assign result_pos = !relu_out_data[DATA_W-1] && (relu_out_data != '0);

    always_comb begin
        state_nxt    = state;
        accept_start = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    accept_start = 1'b1;
                    state_nxt    = (n_clamp == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (rd_cnt == n_q - CNT_W'(1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (wr_cnt == n_q) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            n_q    <= '0;
            rd_cnt <= '0;
            wr_cnt <= '0;
            nz_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept_start) begin
                n_q    <= n_clamp;
                rd_cnt <= '0;
                wr_cnt <= '0;
                nz_q   <= '0;
            end else begin
                if (state == FETCH) begin
                    rd_cnt <= rd_cnt + CNT_W'(1);
                end
                if (wr_accept) begin
                    wr_cnt <= wr_cnt + CNT_W'(1);
                    if (result_pos) begin
                        nz_q <= nz_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rd_en_q <= src_rd_en;
            wr_en_q <= wr_accept;
            if (wr_accept) begin
                wr_addr_q <= wr_cnt[ADDR_W-1:0];
                wr_data_q <= relu_out_data;
            end
        end
    end

    // rd_cnt reaches N after the last read, so the address is gated to stay in range.
    assign src_rd_en     = (state == FETCH);
    assign src_rd_addr   = (state == FETCH) ? rd_cnt[ADDR_W-1:0] : '0;
    assign relu_in_valid = rd_en_q;
    assign relu_in_data  = src_rd_data;
    assign dst_wr_en     = wr_en_q;
    assign dst_wr_addr   = wr_addr_q;
    assign dst_wr_data   = wr_data_q;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign nz_count      = nz_q;

endmodule

// File: tb/tb_relu_layer_sequencer.sv
// Directed bench for relu_layer_sequencer with source-buffer and 1-cycle ReLU models and a write scoreboard.
module tb_relu_layer_sequencer;

    localparam int DATA_W = 16;
    localparam int NN     = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 6;

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  layer_size;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  nz_count;
    logic              src_rd_en;
    logic [ADDR_W-1:0] src_rd_addr;
    logic [DATA_W-1:0] src_rd_data;
    logic [DATA_W-1:0] relu_in_data;
    logic              relu_in_valid;
    logic [DATA_W-1:0] relu_out_data;
    logic              relu_out_valid;
    logic              dst_wr_en;
    logic [ADDR_W-1:0] dst_wr_addr;
    logic [DATA_W-1:0] dst_wr_data;

    relu_layer_sequencer #(
        .DATA_W(DATA_W), .NUM_NEURONS(NN), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .layer_size(layer_size), .busy(busy), .done(done), .nz_count(nz_count),
        .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
        .relu_in_data(relu_in_data), .relu_in_valid(relu_in_valid),
        .relu_out_data(relu_out_data), .relu_out_valid(relu_out_valid),
        .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source buffer (1-cycle read) and registered ReLU models
    logic [DATA_W-1:0] src_mem [0:NN-1];
    logic              relu_q_v;
    logic [DATA_W-1:0] relu_q_d;
    logic              stray;
    logic [DATA_W-1:0] stray_dat;

    initial begin
        src_rd_data = '0;
        relu_q_v    = 1'b0;
        relu_q_d    = '0;
    end

    always @(posedge clk) begin
        if (src_rd_en) src_rd_data <= src_mem[src_rd_addr];
        relu_q_v <= relu_in_valid;
        relu_q_d <= relu_in_data[DATA_W-1] ? '0 : relu_in_data;
    end

    assign relu_out_valid = relu_q_v | stray;
    assign relu_out_data  = stray ? stray_dat : relu_q_d;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t sb_q[$];
    bit  sb_en;
    int  exp_nz;

    always @(negedge clk) begin
        wr_t e;
        if (sb_en && dst_wr_en && !reset) begin
            if (sb_q.size() == 0) begin
                chk("wr_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr", int'(dst_wr_addr), e.addr);
                chk("wr_data", int'($signed(dst_wr_data)), e.data);
            end
        end
    end

    // Pushes the expected writes for a run of the given size over the current src_mem.
    task automatic push_expected(input int size);
        int n;
        int v;
        n = (size > NN) ? NN : size;
        exp_nz = 0;
        for (int i = 0; i < n; i++) begin
            wr_t e;
            v = int'($signed(src_mem[i]));
            e.addr = i;
            e.data = (v > 0) ? v : 0;
            if (v > 0) exp_nz++;
            sb_q.push_back(e);
        end
    endtask

    int r_done_cyc, r_done_n, r_busy_first, r_busy_last;
    int r_rd_n, r_rd_first, r_rv_first, r_wr_n, r_wr_first, r_wr_late, r_nz_after_abort;

    // Start accepted at edge 0; cycle k is sampled at the falling edge following edge k-1.
    task automatic run(input int size, input int abort_at, input int restart_at, input int ncyc);
        @(negedge clk);
        layer_size = CNT_W'(size);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        r_done_cyc = -1; r_done_n = 0; r_busy_first = -1; r_busy_last = -1;
        r_rd_n = 0; r_rd_first = -1; r_rv_first = -1;
        r_wr_n = 0; r_wr_first = -1; r_wr_late = 0; r_nz_after_abort = -1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (busy) begin
                if (r_busy_first < 0) r_busy_first = k;
                r_busy_last = k;
            end
            if (done) begin
                r_done_n++;
                if (r_done_cyc < 0) r_done_cyc = k;
            end
            if (src_rd_en) begin
                r_rd_n++;
                if (r_rd_first < 0) r_rd_first = k;
            end
            if (relu_in_valid && r_rv_first < 0) r_rv_first = k;
            if (dst_wr_en) begin
                r_wr_n++;
                if (r_wr_first < 0) r_wr_first = k;
                if (abort_at > 0 && k > abort_at + 1) r_wr_late++;
            end
            if (abort_at > 0 && k == abort_at + 2) r_nz_after_abort = int'(nz_count);
            abort = (k == abort_at);
            start = (k == restart_at);
            if (k == restart_at) layer_size = CNT_W'(8);
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    int cnt_wr, cnt_done;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; layer_size = '0;
        stray = 1'b0; stray_dat = '0; sb_en = 1'b1; exp_nz = 0;
        for (int i = 0; i < NN; i++) src_mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_nz", int'(nz_count), 0);
        chk("rst_rd_en", int'(src_rd_en), 0);
        chk("rst_rd_addr", int'(src_rd_addr), 0);
        chk("rst_in_valid", int'(relu_in_valid), 0);
        chk("rst_wr_en", int'(dst_wr_en), 0);
        chk("rst_wr_addr", int'(dst_wr_addr), 0);
        chk("rst_wr_data", int'(dst_wr_data), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Nominal N=4
        src_mem[0] = 16'sd1000; src_mem[1] = -16'sd500; src_mem[2] = 16'sd0; src_mem[3] = 16'sd7;
        push_expected(4);
        run(4, 0, 0, 12);
        chk("n4_done_cyc", r_done_cyc, 8);
        chk("n4_done_n", r_done_n, 1);
        chk("n4_busy_first", r_busy_first, 1);
        chk("n4_busy_last", r_busy_last, 8);
        chk("n4_rd_first", r_rd_first, 1);
        chk("n4_rd_n", r_rd_n, 4);
        chk("n4_inv_first", r_rv_first, 2);
        chk("n4_wr_first", r_wr_first, 4);
        chk("n4_wr_n", r_wr_n, 4);
        chk("n4_nz", int'(nz_count), 2);
        chk("n4_nz_model", int'(nz_count), exp_nz);
        chk("n4_sb_left", sb_q.size(), 0);

        // Empty layer
        run(0, 0, 0, 6);
        chk("n0_done_cyc", r_done_cyc, 1);
        chk("n0_busy_last", r_busy_last, 1);
        chk("n0_rd_n", r_rd_n, 0);
        chk("n0_wr_n", r_wr_n, 0);
        chk("n0_nz", int'(nz_count), 0);

        // Oversized layer clamps to NUM_NEURONS
        for (int i = 0; i < NN; i++) src_mem[i] = 16'(i - 16);
        push_expected(40);
        run(40, 0, 0, 44);
        chk("n40_done_cyc", r_done_cyc, 36);
        chk("n40_rd_n", r_rd_n, 32);
        chk("n40_wr_n", r_wr_n, 32);
        chk("n40_nz", int'(nz_count), 15);
        chk("n40_sb_left", sb_q.size(), 0);

        // Second start mid-run is ignored
        src_mem[0] = -16'sd2; src_mem[1] = 16'sd3; src_mem[2] = 16'sd4; src_mem[3] = -16'sd8;
        push_expected(4);
        run(4, 0, 3, 14);
        chk("rs_done_cyc", r_done_cyc, 8);
        chk("rs_done_n", r_done_n, 1);
        chk("rs_wr_n", r_wr_n, 4);
        chk("rs_rd_n", r_rd_n, 4);
        chk("rs_nz", int'(nz_count), 2);
        chk("rs_sb_left", sb_q.size(), 0);

        // Abort in cycle 3 of an N=8 run
        sb_en = 1'b0;
        for (int i = 0; i < 8; i++) src_mem[i] = 16'(10 + i);
        run(8, 3, 0, 12);
        chk("ab_done_n", r_done_n, 0);
        chk("ab_busy_last", r_busy_last, 3);
        chk("ab_rd_n", r_rd_n, 3);
        chk("ab_wr_late", r_wr_late, 0);
        chk("ab_nz_hold", int'(nz_count), r_nz_after_abort);
        chk("ab_busy_now", int'(busy), 0);
        stray_dat = 16'sd55;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        chk("stray_wr_en", int'(dst_wr_en), 0);
        chk("stray_nz", int'(nz_count), r_nz_after_abort);
        // Start and abort together: abort wins
        layer_size = CNT_W'(4);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", int'(busy), 0);
        chk("sa_rd_en", int'(src_rd_en), 0);

        sb_q.delete();
        sb_en = 1'b1;
        src_mem[0] = -16'sd9; src_mem[1] = 16'sd12;
        push_expected(2);
        run(2, 0, 0, 10);
        chk("n2_done_cyc", r_done_cyc, 6);
        chk("n2_wr_n", r_wr_n, 2);
        chk("n2_nz", int'(nz_count), 1);
        chk("n2_sb_left", sb_q.size(), 0);

        // Asynchronous reset mid-DRAIN
        sb_en = 1'b0;
        for (int i = 0; i < 8; i++) src_mem[i] = 16'(100 + i);
        run(8, 0, 0, 9);
        chk("pre_rst_wr_en", int'(dst_wr_en), 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_rd_en", int'(src_rd_en), 0);
        chk("mid_rst_in_valid", int'(relu_in_valid), 0);
        chk("mid_rst_wr_en", int'(dst_wr_en), 0);
        chk("mid_rst_wr_addr", int'(dst_wr_addr), 0);
        chk("mid_rst_wr_data", int'(dst_wr_data), 0);
        chk("mid_rst_nz", int'(nz_count), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cnt_wr = 0;
        cnt_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (dst_wr_en) cnt_wr++;
            if (done) cnt_done++;
        end
        chk("post_rst_wr", cnt_wr, 0);
        chk("post_rst_done", cnt_done, 0);
        chk("post_rst_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/relu_layer_sequencer.md
Name: relu_layer_sequencer

Overview:
Sequences the shared registered ReLU unit over one layer of dense-layer accumulator results. On start it streams up to NUM_NEURONS signed words from a source buffer through the external ReLU and writes the results to a destination buffer, in order. It also counts strictly positive activations. It sits between the dense-layer accumulator bank and the next layer's input buffer in the MNIST inference path.

Parameters:
DATA_W, 16, signed activation/accumulator word width
NUM_NEURONS, 32, maximum neurons per layer (buffer depth)
ADDR_W, $clog2(NUM_NEURONS), buffer address width
CNT_W, $clog2(NUM_NEURONS+1), width of layer_size and nz_count

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to process a layer; sampled only in IDLE
abort  in  1  synchronous cancel of the current run
layer_size  in  CNT_W  neuron count for this run; latched when start is accepted
busy  out  1  high from the cycle after start is accepted until DONE is left
done  out  1  one-cycle pulse when all results are written
nz_count  out  CNT_W  number of written results > 0; held stable after done
src_rd_en  out  1  source buffer read strobe
src_rd_addr  out  ADDR_W  source read address
src_rd_data  in  DATA_W  source read data; valid exactly 1 cycle after src_rd_en
relu_in_data  out  DATA_W  operand to the ReLU unit
relu_in_valid  out  1  operand valid
relu_out_data  in  DATA_W  ReLU result
relu_out_valid  in  1  ReLU result valid
dst_wr_en  out  1  destination write strobe
dst_wr_addr  out  ADDR_W  destination write address
dst_wr_data  out  DATA_W  destination write data

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high.
- Reset values: FSM=IDLE, busy=0, done=0, nz_count=0, src_rd_en=0, src_rd_addr=0, relu_in_valid=0, dst_wr_en=0, dst_wr_addr=0, dst_wr_data=0. All counters are cleared.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE: start=1 at an edge does three things: latches N = min(layer_size, NUM_NEURONS), clears rd_cnt, wr_cnt and nz_count, and moves to FETCH (or DONE if N=0).
- FETCH: src_rd_en=1 and src_rd_addr=rd_cnt every cycle; rd_cnt increments each cycle. After the read with rd_cnt=N-1, move to DRAIN.
- ReLU feed:
  - relu_in_valid is src_rd_en delayed one cycle (registered).
  - relu_in_data = src_rd_data, combinational pass-through, so it is valid while relu_in_valid=1.
  - The controller never issues more than N operands.
- Write path: relu_out_valid=1 in a FETCH or DRAIN cycle registers the following on the next edge: dst_wr_en=1, dst_wr_addr=wr_cnt, dst_wr_data=relu_out_data. It then increments wr_cnt and, if relu_out_data > 0 (signed), increments nz_count.
- The controller does not assume ReLU latency; completion is determined by counting returns.
- DRAIN: wait until wr_cnt==N and the final dst_wr_en has been issued, then move to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE. busy falls with the move to IDLE.
- Nominal timing with the 1-cycle registered ReLU, start accepted at edge 0:
  - rd_en in cycles 1..N
  - relu_in_valid in cycles 2..N+1
  - relu_out_valid in cycles 3..N+2
  - dst_wr_en in cycles 4..N+3
  - done in cycle N+4
- Boundary conditions:
  - start while not IDLE: ignored; the latched N is unchanged.
  - start and abort in the same IDLE cycle: abort wins; stay in IDLE.
  - layer_size=0: no reads or writes; done pulses the cycle after acceptance; nz_count=0.
  - layer_size>NUM_NEURONS: clamped to NUM_NEURONS.
  - relu_out_valid while IDLE or DONE: ignored; no write, no count change.
  - Excess relu_out_valid after wr_cnt==N: ignored.
  - abort=1 in FETCH or DRAIN: next state IDLE, with src_rd_en=0 and busy=0. No done pulse. nz_count holds its partial value. Late ReLU returns are then ignored.
  - Reset mid-run: immediate return to reset values. No done, no further writes.
- Address wrap: rd_cnt and wr_cnt never exceed N-1 as addresses, so there is no wrap at NUM_NEURONS.

Test Plan:
- N=4, src={1000,-500,0,7}, start at edge 0 -> dst[0..3]={1000,0,0,7}; done in cycle 8; nz_count=2; busy in cycles 1..8.
- layer_size=0 -> no src_rd_en or dst_wr_en; done 1 cycle after start; nz_count=0.
- layer_size=40 with NUM_NEURONS=32, src[i]=i-16 -> 32 writes with dst[i]=max(i-16,0); nz_count=15; done in cycle 36.
- Second start pulse in cycle 3 of an N=4 run -> ignored; exactly 4 writes and one done pulse.
- abort in cycle 3 of an N=8 run -> back to IDLE with no done. A stray relu_out_valid afterwards causes no write. A subsequent start with N=2 completes normally.
- reset asserted asynchronously mid-DRAIN -> all outputs go to reset values immediately; no writes after release.
